writeback_unit: RTL

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/writeback_unit.sv | 122 ++++++++++++
 1 files changed

// File: rtl/writeback_unit.sv
// Two-stage memory/writeback pipeline (M, W) feeding the register file, with
// combinational M/W result forwarding, load-use stall detection and a commit counter.
module writeback_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic [2:0]  ex_dest,
  input  logic [15:0] ex_alu_result,
  input  logic [15:0] mem_read_data,
  input  logic        flush,
  input  logic [2:0]  read_addr1,
  input  logic [2:0]  read_addr2,
  output logic        reg_write,
  output logic [2:0]  write_addr,
  output logic [15:0] write_data,
  output logic        fwd1_hit,
  output logic        fwd2_hit,
  output logic [15:0] fwd1_data,
  output logic [15:0] fwd2_data,
  output logic        load_stall,
  output logic [15:0] wb_count
);

  localparam int unsigned DataW = 16;
  localparam int unsigned RegAw = 3;
  localparam int unsigned CntW  = 16;

  typedef struct packed {
    logic             valid;
    logic             we;
    logic             load;
    logic [RegAw-1:0] dest;
    logic [DataW-1:0] alu;
  } m_stage_t;

  m_stage_t         m_q, m_d;
  logic             reg_write_q, reg_write_d;
  logic [RegAw-1:0] write_addr_q, write_addr_d;
  logic [DataW-1:0] write_data_q, write_data_d;
  logic [CntW-1:0]  wb_count_q, wb_count_d;

  logic m_alu_wr;
  logic m_load_wr;
  logic m_ld_match1;
  logic m_ld_match2;

  // Next-state for both stages and the commit counter.
  always_comb begin
    m_d          = '0;
    m_d.valid    = ex_valid;
    m_d.we       = ex_reg_write;
    m_d.load     = ex_mem_read;
    m_d.dest     = ex_dest;
    m_d.alu      = ex_alu_result;

    // Flush only kills the instruction leaving M; whatever is already in W commits.
    reg_write_d  = m_q.valid & m_q.we & ~flush;
    write_addr_d = m_q.dest;
    write_data_d = m_q.load ? mem_read_data : m_q.alu;

    wb_count_d   = wb_count_q;
    if (reg_write_q) begin
      wb_count_d = wb_count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q          <= '0;
      reg_write_q  <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      wb_count_q   <= '0;
    end else begin
      m_q          <= m_d;
      reg_write_q  <= reg_write_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      wb_count_q   <= wb_count_d;
    end
  end

  assign m_alu_wr    = m_q.valid & m_q.we & ~m_q.load;
  assign m_load_wr   = m_q.valid & m_q.we & m_q.load;
  assign m_ld_match1 = m_load_wr & (m_q.dest == read_addr1);
  assign m_ld_match2 = m_load_wr & (m_q.dest == read_addr2);

  // Forwarding: M beats W; a pending load to the same register blocks the older W value.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    if (m_alu_wr && (m_q.dest == read_addr1)) begin
      fwd1_hit  = 1'b1;
      fwd1_data = m_q.alu;
    end else if (reg_write_q && (write_addr_q == read_addr1) && !m_ld_match1) begin
      fwd1_hit  = 1'b1;
      fwd1_data = write_data_q;
    end
  end

  always_comb begin
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    if (m_alu_wr && (m_q.dest == read_addr2)) begin
      fwd2_hit  = 1'b1;
      fwd2_data = m_q.alu;
    end else if (reg_write_q && (write_addr_q == read_addr2) && !m_ld_match2) begin
      fwd2_hit  = 1'b1;
      fwd2_data = write_data_q;
    end
  end

  assign load_stall = m_ld_match1 | m_ld_match2;

  assign reg_write  = reg_write_q;
  assign write_addr = write_addr_q;
  assign write_data = write_data_q;
  assign wb_count   = wb_count_q;

endmodule
